// File: rtl/csi_dphy_frame_gen.sv
// CSI-2 frame generator driving a D-PHY RX byte interface for self-test and emulation.
// Each frame is an FS short packet, `lines` long line packets and an FE short packet.
// A long packet is a header, a patterned payload and a CRC-16.
// Consecutive packets are separated by GAP_CYCLES idle cycles.
//
// Ports:
//   clk_i, reset_n_i     byte clock, asynchronous active-low reset
//   start_i              one-cycle frame request, accepted only when idle
//   vc_id_i, data_type_i, word_count_i, lines_i, active_lanes_i, pattern_sel_i
//                        frame configuration, latched when start_i is accepted
//   busy_o, done_o       frame in progress / one-cycle pulse after the FE packet
//   frame_num_o          number of the current or last frame (FS/FE word count)
//   rx_valid_hs_o        per-lane byte valid
//   rx_data_hs_o         lane l at [l*MIPI_GEAR +: MIPI_GEAR], sub-byte s at [s*8 +: 8]
module csi_dphy_frame_gen #(
  parameter int unsigned MIPI_LANES = 4,
  parameter int unsigned MIPI_GEAR  = 8,
  parameter int unsigned NUM_VC     = 4,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic                             start_i,
  input  logic [1:0]                       vc_id_i,
  input  logic [5:0]                       data_type_i,
  input  logic [15:0]                      word_count_i,
  input  logic [15:0]                      lines_i,
  input  logic [2:0]                       active_lanes_i,
  input  logic [1:0]                       pattern_sel_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic [15:0]                      frame_num_o,
  output logic [MIPI_LANES-1:0]            rx_valid_hs_o,
  output logic [MIPI_LANES*MIPI_GEAR-1:0]  rx_data_hs_o
);

  localparam int unsigned BytesPerLane = MIPI_GEAR / 8;
  localparam int unsigned DataW        = MIPI_LANES * MIPI_GEAR;
  localparam int unsigned GapW         = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {StIdle, StFs, StGap, StLong, StFe, StDone} state_e;

  // CSI-2 v1.x header ECC: d = {wc_hi, wc_lo, di}
  function automatic logic [5:0] ecc6(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    return p;
  endfunction

  // Reflected CRC-16 (x^16+x^12+x^5+1), data consumed LSB first
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      c = (c >> 1) ^ ((c[0] ^ b[i]) ? 16'h8408 : 16'h0000);
    end
    return c;
  endfunction

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1, advanced 8 bits per payload byte
  function automatic logic [7:0] lfsr8_step(input logic [7:0] s_in);
    logic [7:0] s;
    s = s_in;
    for (int i = 0; i < 8; i++) begin
      s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    end
    return s;
  endfunction

  state_e            state_q, state_d;
  logic [16:0]       pos_q, pos_d;       // packet byte index of the first slot shown this cycle
  logic [GapW-1:0]   gap_q, gap_d;
  logic [15:0]       line_q, line_d;     // index of the current / next line packet
  logic [1:0]        vc_q, vc_d, vc_in;
  logic [5:0]        dt_q, dt_d;
  logic [15:0]       wc_q, wc_d;
  logic [15:0]       lines_q, lines_d;
  logic [2:0]        lanes_q, lanes_d, lanes_in;
  logic [1:0]        pat_q, pat_d;
  logic [15:0]       frame_q, frame_d;
  logic [15:0]       crc_q, crc_d;
  logic [7:0]        lfsr_q, lfsr_d;
  logic [MIPI_LANES-1:0] valid_q, valid_d;
  logic [DataW-1:0]  data_q, data_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              accept;

  logic [16:0]       bpc, pkt_len_q;
  logic              last_beat;

  // Unsupported lane requests fall back to a single lane
  always_comb begin
    lanes_in = 3'd1;
    if ((active_lanes_i == 3'd2 && MIPI_LANES >= 2) ||
        (active_lanes_i == 3'd4 && MIPI_LANES >= 4)) begin
      lanes_in = active_lanes_i;
    end
    vc_in = (32'(vc_id_i) >= NUM_VC) ? 2'd0 : vc_id_i;
  end

  assign bpc       = {14'd0, lanes_q} * 17'(BytesPerLane);
  assign pkt_len_q = (state_q == StLong) ? ({1'b0, wc_q} + 17'd6) : 17'd4;
  assign last_beat = (pos_q + bpc) >= pkt_len_q;

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= StIdle;
      pos_q   <= '0;
      gap_q   <= '0;
      line_q  <= '0;
      vc_q    <= '0;
      dt_q    <= '0;
      wc_q    <= '0;
      lines_q <= '0;
      lanes_q <= 3'd1;
      pat_q   <= '0;
      frame_q <= '0;
      crc_q   <= '0;
      lfsr_q  <= '0;
      valid_q <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      gap_q   <= gap_d;
      line_q  <= line_d;
      vc_q    <= vc_d;
      dt_q    <= dt_d;
      wc_q    <= wc_d;
      lines_q <= lines_d;
      lanes_q <= lanes_d;
      pat_q   <= pat_d;
      frame_q <= frame_d;
      crc_q   <= crc_d;
      lfsr_q  <= lfsr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    gap_d   = gap_q;
    line_d  = line_q;
    vc_d    = vc_q;
    dt_d    = dt_q;
    wc_d    = wc_q;
    lines_d = lines_q;
    lanes_d = lanes_q;
    pat_d   = pat_q;
    frame_d = frame_q;
    accept  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          accept  = 1'b1;
          state_d = StFs;
          pos_d   = '0;
          line_d  = '0;
          vc_d    = vc_in;
          dt_d    = data_type_i;
          wc_d    = word_count_i;
          lines_d = lines_i;
          lanes_d = lanes_in;
          pat_d   = pattern_sel_i;
          frame_d = (frame_q == 16'hFFFF) ? 16'd1 : frame_q + 16'd1;
        end
      end
      StFs, StLong, StFe: begin
        if (last_beat) begin
          pos_d = '0;
          gap_d = '0;
          if (state_q == StFe) begin
            state_d = StDone;
          end else begin
            if (state_q == StLong) line_d = line_q + 16'd1;
            if (GAP_CYCLES == 0) state_d = (line_d < lines_q) ? StLong : StFe;
            else                 state_d = StGap;
          end
        end else begin
          pos_d = pos_q + bpc;
        end
      end
      StGap: begin
        if ((32'(gap_q) + 32'd1) >= GAP_CYCLES) state_d = (line_q < lines_q) ? StLong : StFe;
        else                                    gap_d   = gap_q + GapW'(1);
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic: builds the next registered beat from the next state, so the first FS
  // byte appears the cycle after acceptance.
  logic [7:0]  hdr_di, slot_b;
  logic [15:0] hdr_wc, crc_run;
  logic [5:0]  hdr_ecc;
  logic [7:0]  lfsr_run;
  logic [16:0] slot_p, len_d, pay_end;
  logic        emit;
  int          lanes_n;

  always_comb begin
    valid_d  = '0;
    data_d   = '0;
    busy_d   = (state_d == StFs) || (state_d == StGap) || (state_d == StLong) ||
               (state_d == StFe);
    done_d   = (state_d == StDone);
    emit     = (state_d == StFs) || (state_d == StLong) || (state_d == StFe);
    lanes_n  = int'(lanes_d);
    crc_run  = (state_d == StLong && pos_d == '0) ? 16'hFFFF : crc_q;
    lfsr_run = accept ? 8'hFF : lfsr_q;
    slot_p   = '0;
    slot_b   = '0;
    pay_end  = {1'b0, wc_d} + 17'd4;
    len_d    = (state_d == StLong) ? ({1'b0, wc_d} + 17'd6) : 17'd4;
    if (state_d == StLong) begin
      hdr_di = {vc_d, dt_d};
      hdr_wc = wc_d;
    end else begin
      hdr_di = {vc_d, 5'd0, (state_d == StFe)};
      hdr_wc = frame_d;
    end
    hdr_ecc = ecc6({hdr_wc, hdr_di});
    if (emit) begin
      // s outer, l inner walks the slots in increasing packet byte order, which keeps the
      // running CRC / LFSR chain in transmit order.
      for (int s = 0; s < int'(BytesPerLane); s++) begin
        for (int l = 0; l < int'(MIPI_LANES); l++) begin
          if (l < lanes_n) begin
            slot_p = pos_d + 17'(s * lanes_n + l);
            if (slot_p < len_d) begin
              if (slot_p < 17'd4) begin
                case (slot_p[1:0])
                  2'd0:    slot_b = hdr_di;
                  2'd1:    slot_b = hdr_wc[7:0];
                  2'd2:    slot_b = hdr_wc[15:8];
                  default: slot_b = {2'b00, hdr_ecc};
                endcase
              end else if (slot_p < pay_end) begin
                unique case (pat_d)
                  2'd0: slot_b = slot_p[7:0] - 8'd4;
                  2'd1: slot_b = 8'hA5;
                  2'd2: slot_b = line_d[7:0];
                  2'd3: slot_b = lfsr_run;
                endcase
                crc_run  = crc16_byte(crc_run, slot_b);
                lfsr_run = lfsr8_step(lfsr_run);
              end else if (slot_p == pay_end) begin
                slot_b = crc_run[7:0];
              end else begin
                slot_b = crc_run[15:8];
              end
              valid_d[l] = 1'b1;
              data_d[l*int'(MIPI_GEAR) + s*8 +: 8] = slot_b;
            end
          end
        end
      end
    end
    crc_d  = crc_run;
    lfsr_d = lfsr_run;
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign frame_num_o   = frame_q;
  assign rx_valid_hs_o = valid_q;
  assign rx_data_hs_o  = data_q;

endmodule

// File: tb/tb_csi_dphy_frame_gen.sv
// Self-checking bench for csi_dphy_frame_gen: a queue-based frame model builds each
// packet as a byte list and stripes it over the lanes; DUT beats are compared per cycle.
module tb_csi_dphy_frame_gen;

  localparam int unsigned NL   = 4;
  localparam int unsigned GEAR = 8;
  localparam int unsigned NVC  = 4;
  localparam int unsigned GAP  = 2;
  localparam int unsigned DW   = NL * GEAR;
  localparam int unsigned BPL  = GEAR / 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [1:0]    vc_id;
  logic [5:0]    data_type;
  logic [15:0]   word_count;
  logic [15:0]   lines;
  logic [2:0]    active_lanes;
  logic [1:0]    pattern_sel;
  logic          busy, done;
  logic [15:0]   frame_num;
  logic [NL-1:0] rx_valid;
  logic [DW-1:0] rx_data;

  always #5 clk = ~clk;

  csi_dphy_frame_gen #(
    .MIPI_LANES (NL),
    .MIPI_GEAR  (GEAR),
    .NUM_VC     (NVC),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n),
    .start_i        (start),
    .vc_id_i        (vc_id),
    .data_type_i    (data_type),
    .word_count_i   (word_count),
    .lines_i        (lines),
    .active_lanes_i (active_lanes),
    .pattern_sel_i  (pattern_sel),
    .busy_o         (busy),
    .done_o         (done),
    .frame_num_o    (frame_num),
    .rx_valid_hs_o  (rx_valid),
    .rx_data_hs_o   (rx_data)
  );

  typedef struct packed {
    logic          busy;
    logic          done;
    logic [NL-1:0] valid;
    logic [DW-1:0] data;
  } cyc_t;

  cyc_t       exp_q[$];
  cyc_t       obs_q[$];
  logic [7:0] pkt[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [15:0] fc_model = 16'd0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ECC as XOR of the per-bit syndrome columns of the CSI-2 Hamming code
  function automatic logic [5:0] ecc_ref(input logic [23:0] d);
    logic [5:0] cols [24];
    logic [5:0] e;
    cols = '{6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19, 6'h1A, 6'h1C, 6'h23,
             6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C, 6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F,
             6'h37, 6'h3B};
    e = '0;
    for (int i = 0; i < 24; i++) if (d[i]) e ^= cols[i];
    return e;
  endfunction

  function automatic logic [15:0] crc_ref(input logic [7:0] d[$]);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    foreach (d[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ d[i][b];
        c  = c >> 1;
        if (fb) c ^= 16'h8408;
      end
    end
    return c;
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    logic [7:0] r;
    r = s;
    for (int i = 0; i < 8; i++) r = {r[6:0], ^(r & 8'hB8)};
    return r;
  endfunction

  task automatic push_header(input logic [7:0] di, input logic [15:0] wc);
    pkt.push_back(di);
    pkt.push_back(wc[7:0]);
    pkt.push_back(wc[15:8]);
    pkt.push_back({2'b00, ecc_ref({wc, di})});
  endtask

  // Packet byte idx = cycle*L*BPL + s*L + l
  task automatic stripe(input int L);
    int   per, n, nc, idx;
    cyc_t e;
    per = L * int'(BPL);
    n   = pkt.size();
    nc  = (n + per - 1) / per;
    for (int c = 0; c < nc; c++) begin
      e = '0;
      e.busy = 1'b1;
      for (int l = 0; l < L; l++) begin
        for (int s = 0; s < int'(BPL); s++) begin
          idx = c * per + s * L + l;
          if (idx < n) begin
            e.data  |= DW'(pkt[idx]) << (l * int'(GEAR) + s * 8);
            e.valid |= NL'(1) << l;
          end
        end
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic add_gap();
    cyc_t e;
    e = '0;
    e.busy = 1'b1;
    for (int g = 0; g < int'(GAP); g++) exp_q.push_back(e);
  endtask

  task automatic build_frame(input logic [1:0] vc_in, input logic [5:0] dt, input logic [15:0] wc,
                             input logic [15:0] nlines, input logic [2:0] lanes_in,
                             input logic [1:0] pat);
    int          L;
    logic [1:0]  vc;
    logic [7:0]  lf;
    logic [15:0] crc;
    logic [7:0]  pay[$];
    cyc_t        e;
    L  = ((lanes_in == 3'd2 && NL >= 2) || (lanes_in == 3'd4 && NL >= 4)) ? int'(lanes_in) : 1;
    vc = (int'(vc_in) >= int'(NVC)) ? 2'd0 : vc_in;
    fc_model = (fc_model == 16'hFFFF) ? 16'd1 : fc_model + 16'd1;
    exp_q.delete();
    lf = 8'hFF;
    pkt.delete();
    push_header({vc, 6'h00}, fc_model);
    stripe(L);
    add_gap();
    for (int ln = 0; ln < int'(nlines); ln++) begin
      pay.delete();
      for (int i = 0; i < int'(wc); i++) begin
        case (pat)
          2'd0: pay.push_back(8'(i));
          2'd1: pay.push_back(8'hA5);
          2'd2: pay.push_back(8'(ln));
          default: begin
            pay.push_back(lf);
            lf = lfsr_next(lf);
          end
        endcase
      end
      crc = crc_ref(pay);
      pkt.delete();
      push_header({vc, dt}, wc);
      foreach (pay[i]) pkt.push_back(pay[i]);
      pkt.push_back(crc[7:0]);
      pkt.push_back(crc[15:8]);
      stripe(L);
      add_gap();
    end
    pkt.delete();
    push_header({vc, 6'h01}, fc_model);
    stripe(L);
    e = '0;
    e.done = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic run_frame(input logic [1:0] vc_in, input logic [5:0] dt, input logic [15:0] wc,
                           input logic [15:0] nlines, input logic [2:0] lanes_in,
                           input logic [1:0] pat, input bit disturb);
    cyc_t cur;
    build_frame(vc_in, dt, wc, nlines, lanes_in, pat);
    obs_q.delete();
    @(negedge clk);
    vc_id = vc_in; data_type = dt; word_count = wc; lines = nlines;
    active_lanes = lanes_in; pattern_sel = pat; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    foreach (exp_q[i]) begin
      cur.busy = busy; cur.done = done; cur.valid = rx_valid; cur.data = rx_data;
      obs_q.push_back(cur);
      check_eq($sformatf("valid@%0d", i), 64'(cur.valid), 64'(exp_q[i].valid));
      check_eq($sformatf("data@%0d", i), 64'(cur.data), 64'(exp_q[i].data));
      check_eq($sformatf("busy_done@%0d", i), 64'({cur.busy, cur.done}),
               64'({exp_q[i].busy, exp_q[i].done}));
      // Mid-frame config churn and start requests must be ignored
      if (disturb && (i + 1 < exp_q.size())) begin
        vc_id = 2'($urandom); data_type = 6'($urandom); word_count = 16'($urandom);
        lines = 16'($urandom); active_lanes = 3'($urandom); pattern_sel = 2'($urandom);
        start = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    check_eq("idle_busy", 64'(busy), 64'(0));
    check_eq("idle_valid", 64'(rx_valid), 64'(0));
    check_eq("frame_num", 64'(frame_num), 64'(fc_model));
  endtask

  function automatic int count_busy();
    int n;
    n = 0;
    foreach (obs_q[i]) if (obs_q[i].busy) n++;
    return n;
  endfunction

  function automatic int count_done();
    int n;
    n = 0;
    foreach (obs_q[i]) if (obs_q[i].done) n++;
    return n;
  endfunction

  initial begin
    reset_n = 1'b0; start = 1'b0; vc_id = '0; data_type = '0; word_count = '0;
    lines = '0; active_lanes = 3'd4; pattern_sel = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_done", 64'(done), 64'(0));
    check_eq("rst_valid", 64'(rx_valid), 64'(0));
    check_eq("rst_data", 64'(rx_data), 64'(0));
    check_eq("rst_frame_num", 64'(frame_num), 64'(0));

    // Four lanes, two RAW8 lines of 16 bytes
    run_frame(2'd0, 6'h2A, 16'd16, 16'd2, 3'd4, 2'd0, 1'b0);
    check_eq("t1_busy_cycles", 64'(count_busy()), 64'(20));
    check_eq("t1_done_pulses", 64'(count_done()), 64'(1));
    check_eq("t1_last_line_valid", 64'(obs_q[16].valid), 64'(4'b0011));

    // One lane: payload visible byte by byte on lane 0
    run_frame(2'd0, 6'h2A, 16'd16, 16'd2, 3'd1, 2'd0, 1'b0);
    check_eq("t2_busy_cycles", 64'(count_busy()), 64'(58));
    for (int j = 0; j < 16; j += 5) begin
      check_eq($sformatf("t2_payload%0d", j), 64'(obs_q[10+j].data[7:0]), 64'(j));
      check_eq($sformatf("t2_lanes%0d", j), 64'(obs_q[10+j].valid), 64'(4'b0001));
    end

    // No lines, VC3, unsupported lane count
    run_frame(2'd3, 6'h2A, 16'd8, 16'd0, 3'd3, 2'd1, 1'b0);
    check_eq("t3_busy_cycles", 64'(count_busy()), 64'(10));
    check_eq("t3_fs_di", 64'(obs_q[0].data[7:0]), 64'(8'hC0));
    check_eq("t3_fe_di", 64'(obs_q[6].data[7:0]), 64'(8'hC1));

    // Asynchronous reset in the middle of a payload
    @(negedge clk);
    word_count = 16'd40; lines = 16'd2; active_lanes = 3'd1; pattern_sel = 2'd3;
    vc_id = 2'd1; data_type = 6'h2B; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("pre_reset_busy", 64'(busy), 64'(1));
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_valid", 64'(rx_valid), 64'(0));
    check_eq("async_rst_data", 64'(rx_data), 64'(0));
    check_eq("async_rst_busy", 64'(busy), 64'(0));
    check_eq("async_rst_frame_num", 64'(frame_num), 64'(0));
    @(negedge clk);
    reset_n = 1'b1;
    fc_model = 16'd0;

    // Randomized frames with mid-frame disturbance
    for (int f = 0; f < 25; f++) begin
      run_frame(2'($urandom), 6'($urandom), 16'($urandom_range(0, 40)),
                16'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 2'($urandom), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/csi_dphy_frame_gen.md
Name: csi_dphy_frame_gen

Overview:
Synthesisable CSI-2 frame generator that drives the D-PHY RX byte interface (per-lane valid plus byte data) of top_csi for on-chip self-test and emulation. It builds complete frames: FS short packet, N long line packets (header, ECC, patterned payload, CRC-16), then an FE short packet. Lane count, gear, inter-packet gap and virtual-channel count are parametrised; lane count, VC and data type are selected at run time.

Parameters:
MIPI_LANES, 4, physical lanes driven (1, 2 or 4)
MIPI_GEAR, 8, bits per lane per clock (8 or 16; GEAR/8 bytes per lane per cycle)
NUM_VC, 4, number of supported virtual channels; vc_id_i >= NUM_VC is clamped to 0
GAP_CYCLES, 2, idle cycles (all valids low) between consecutive packets

Ports:
clk_i  in  1  byte clock
reset_n_i  in  1  asynchronous active-low reset
start_i  in  1  single-cycle request to send one frame
vc_id_i  in  2  virtual channel for the frame
data_type_i  in  6  DT field of line packets (e.g. RAW8 0x2A)
word_count_i  in  16  payload bytes per line
lines_i  in  16  lines per frame (0 = FS/FE only)
active_lanes_i  in  3  lanes used: 1, 2 or 4; any other value is treated as 1
pattern_sel_i  in  2  0 incrementing byte (restarts each line), 1 constant 0xA5, 2 line index LSB, 3 LFSR-8 (x^8+x^6+x^5+x^4+1, seed 0xFF per frame)
busy_o  out  1  frame in progress
done_o  out  1  one-cycle pulse after FE's last byte
frame_num_o  out  16  number of last frame sent (FS/FE WC)
rx_valid_hs_o  out  MIPI_LANES  per-lane byte-valid
rx_data_hs_o  out  MIPI_LANES*MIPI_GEAR  lane data, lane l at [l*GEAR +: GEAR]

Behaviour:
- Reset: all outputs 0, FSM IDLE, frame counter 0. Reset mid-frame aborts immediately; no partial packet resumes.
- Config (vc, DT, WC, lines, lanes, pattern) latched on accepted start_i; later changes are ignored until the next frame.
- start_i accepted only in IDLE; ignored while busy_o=1. busy_o rises the cycle after acceptance and falls with done_o.
- Frame counter increments on acceptance and wraps 0xFFFF -> 1 (0 is never sent). FS/FE WC = counter value.
- FSM: IDLE -> SHORT(FS) -> GAP -> [LONG -> GAP] x lines -> SHORT(FE) -> DONE -> IDLE. DONE lasts one cycle and drives done_o=1.
- Packet header: byte0 = {vc[1:0], DT[5:0]} (FS DT 0x00, FE DT 0x01), byte1 = WC[7:0], byte2 = WC[15:8], byte3 = {2'b00, ECC[5:0]}. ECC is the CSI-2 v1.x Hamming over 24 header bits.
- Long packet = header, WC payload bytes, CRC-16 (poly x^16+x^12+x^5+1, seed 0xFFFF, reflected, LSB-first), CRC low byte first. WC=0 gives a header followed directly by CRC 0xFFFF.
- Byte striping: within a cycle, packet byte index = base + s*L + l, where L = active lanes, l = lane, s = sub-byte (0..GEAR/8-1, sub-byte s at bits [s*8 +: 8] of lane l). base advances by L*GEAR/8 per cycle.
- Final cycle of a packet: only lanes carrying bytes have valid=1; others have valid=0 and data 0. Inactive lanes (l >= L) have valid=0 and data 0 at all times. With GEAR=16 an odd trailing byte is placed in sub-byte 0, sub-byte 1 = 0x00, and valid stays 1 (the receiver uses the WC).
- GAP: GAP_CYCLES cycles with all valids 0. GAP_CYCLES=0 means packets are back-to-back.
- First FS byte appears at the cycle after start_i is accepted (1-cycle latency). All outputs are registered.

Test Plan:
- Reset then start, lanes=4, GEAR=8, WC=16, lines=2, GAP=2, RAW8, VC0 -> 20 busy cycles: FS 1, gap 2, line 6, gap 2, line 6, gap 2, FE 1; last line cycle has valid=4'b0011. done_o pulses once, frame_num_o=1.
- Same frame with lanes=1 -> each line takes 22 cycles, lane0 bytes are header, payload 0x00..0x0F, then CRC. Check ECC and CRC against a bench reference function; lanes 1-3 stay valid=0.
- Frame fed into top_csi with RAW8, pattern 0 -> no err_frame_sync_o or err_frame_data_o. ECC, CRC and decoded WC match.
- start_i reasserted mid-frame, config inputs toggled mid-frame -> ignored; packet contents use the latched values.
- Reset asserted during payload -> all outputs 0 within the same cycle (async). Next start sends a clean frame with frame_num 1.
- lines=0, VC=3, active_lanes_i=3 -> FS, gap, FE on lane0 only. DI bytes 0xC0 and 0xC1.
